// File: rtl/mlp_sequencer.sv
// mlp_sequencer: time-shared single-MAC sequencer for a 2-layer MLP denoiser.
// Buffers one N1-sample vector, runs layer 1 through the tanh LUT, runs layer 2
// and returns one saturated W_OUT result per vector. LUT reads are combinational.
module mlp_sequencer #(
   parameter int N1        = 98,
   parameter int N2        = 10,
   parameter int W_K       = 4,
   parameter int W_X       = 8,
   parameter int W_OUT     = 16,
   parameter int ACT_SHIFT = 4,
   parameter int OUT_SHIFT = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [W_X-1:0]               s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [W_OUT-1:0]             m_data,
   output logic                         busy,
   output logic [1:0]                   w_sel,
   output logic [$clog2(N2+1)-1:0]      w_neuron,
   output logic [$clog2(N1/2+1)-1:0]    w_idx,
   input  logic [W_K-1:0]               w_data,
   output logic [W_K-1:0]               tanh_idx,
   input  logic [W_OUT-1:0]             tanh_data
);

   localparam int HALF   = N1 / 2;
   localparam int CNT_W  = $clog2(N1);
   localparam int NEU_W  = $clog2(N2 + 1);
   localparam int IDX_W  = $clog2(N1 / 2 + 1);
   localparam int HID_W  = $clog2(N2);
   localparam int ACC1_W = W_X + W_K + $clog2(N1 + 2) + 1;
   localparam int ACC2_W = W_OUT + W_K + $clog2(N2 + 1) + 1;

   localparam logic signed [ACC1_W-1:0] T_MAX = ACC1_W'(2 ** (W_K - 1) - 1);
   localparam logic signed [ACC1_W-1:0] T_MIN = ACC1_W'(-(2 ** (W_K - 1)));
   localparam logic signed [ACC2_W-1:0] O_MAX = ACC2_W'(2 ** (W_OUT - 1) - 1);
   localparam logic signed [ACC2_W-1:0] O_MIN = ACC2_W'(-(2 ** (W_OUT - 1)));

   typedef enum logic [2:0] {
      S_LOAD, S_L1_MAC, S_L1_BIAS_M, S_L1_BIAS_P, S_L1_ACT, S_L2_MAC, S_L2_BIAS, S_OUT
   } state_t;

   state_t                     r_state, w_next;
   logic [CNT_W-1:0]           r_cnt;
   logic [NEU_W-1:0]           r_neuron;
   logic signed [ACC1_W-1:0]   r_acc1;
   logic signed [ACC2_W-1:0]   r_acc2;
   logic                       r_m_valid;
   logic [W_OUT-1:0]           r_m_data;
   logic signed [W_X-1:0]      r_x [N1];
   logic signed [W_OUT-1:0]    r_h [N2];

   logic                       w_s_hs, w_last_x, w_last_h, w_last_neuron;
   logic signed [ACC1_W-1:0]   w_w1, w_x1, w_prod1, w_shift1, w_t;
   logic signed [ACC2_W-1:0]   w_w2, w_h2, w_shift2, w_o;
   logic [W_K-1:0]             w_tanh_idx;
   logic [W_OUT-1:0]           w_sat;

   assign s_ready       = rstn && (r_state == S_LOAD);
   assign busy          = rstn && (r_state != S_LOAD);
   assign m_valid       = r_m_valid;
   assign m_data        = r_m_data;
   assign w_s_hs        = s_valid && s_ready;
   assign w_last_x      = (r_cnt == CNT_W'(N1 - 1));
   assign w_last_h      = (r_cnt == CNT_W'(N2 - 1));
   assign w_last_neuron = (r_neuron == NEU_W'(N2 - 1));

   // Datapath arithmetic: sign-extended MAC operands, activation clamp, output saturation
   always_comb begin
      w_w1     = ACC1_W'($signed(w_data));
      w_x1     = ACC1_W'(r_x[r_cnt]);
      w_prod1  = w_w1 * w_x1;
      w_w2     = ACC2_W'($signed(w_data));
      w_h2     = ACC2_W'(r_h[r_cnt[HID_W-1:0]]);
      w_shift1 = r_acc1 >>> ACT_SHIFT;
      if (w_shift1 > T_MAX)      w_t = T_MAX;
      else if (w_shift1 < T_MIN) w_t = T_MIN;
      else                       w_t = w_shift1;
      w_tanh_idx = W_K'(w_t - T_MIN);
      w_shift2 = r_acc2 >>> OUT_SHIFT;
      if (w_shift2 > O_MAX)      w_o = O_MAX;
      else if (w_shift2 < O_MIN) w_o = O_MIN;
      else                       w_o = w_shift2;
      w_sat = W_OUT'(w_o);
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD:      if (w_s_hs && w_last_x) w_next = S_L1_MAC;
         S_L1_MAC:    if (w_last_x) w_next = S_L1_BIAS_M;
         S_L1_BIAS_M: w_next = S_L1_BIAS_P;
         S_L1_BIAS_P: w_next = S_L1_ACT;
         S_L1_ACT:    w_next = w_last_neuron ? S_L2_MAC : S_L1_MAC;
         S_L2_MAC:    if (w_last_h) w_next = S_L2_BIAS;
         S_L2_BIAS:   w_next = S_OUT;
         S_OUT:       if (r_m_valid && m_ready) w_next = S_LOAD;
         default:     w_next = S_LOAD;
      endcase
   end

   // LUT address decode from registered state/counters; zero when unused
   always_comb begin
      w_sel    = '0;
      w_neuron = '0;
      w_idx    = '0;
      tanh_idx = '0;
      case (r_state)
         S_L1_MAC: begin
            w_neuron = r_neuron;
            if (r_cnt < CNT_W'(HALF)) begin
               w_sel = 2'd0;
               w_idx = IDX_W'(r_cnt);
            end else begin
               w_sel = 2'd1;
               w_idx = IDX_W'(r_cnt - CNT_W'(HALF));
            end
         end
         S_L1_BIAS_M: begin
            w_neuron = r_neuron;
            w_sel    = 2'd0;
            w_idx    = IDX_W'(HALF);
         end
         S_L1_BIAS_P: begin
            w_neuron = r_neuron;
            w_sel    = 2'd1;
            w_idx    = IDX_W'(HALF);
         end
         S_L1_ACT:  tanh_idx = w_tanh_idx;
         S_L2_MAC: begin
            w_sel = 2'd2;
            w_idx = IDX_W'(r_cnt);
         end
         S_L2_BIAS: begin
            w_sel = 2'd2;
            w_idx = IDX_W'(N2);
         end
         default: ;
      endcase
   end

   // State, counters, accumulators and registered output; m_valid rises one
   // cycle after entering OUT so the result is driven straight from a flop
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_LOAD;
         r_cnt     <= '0;
         r_neuron  <= '0;
         r_acc1    <= '0;
         r_acc2    <= '0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_LOAD: begin
               if (w_s_hs) begin
                  r_cnt <= w_last_x ? '0 : r_cnt + 1'b1;
                  if (w_last_x) begin
                     r_neuron <= '0;
                     r_acc1   <= '0;
                     r_acc2   <= '0;
                  end
               end
            end
            S_L1_MAC: begin
               r_acc1 <= r_acc1 + w_prod1;
               r_cnt  <= w_last_x ? '0 : r_cnt + 1'b1;
            end
            S_L1_BIAS_M, S_L1_BIAS_P: r_acc1 <= r_acc1 + w_w1;
            S_L1_ACT: begin
               r_acc1   <= '0;
               r_neuron <= r_neuron + 1'b1;
            end
            S_L2_MAC: begin
               r_acc2 <= r_acc2 + w_w2 * w_h2;
               r_cnt  <= w_last_h ? '0 : r_cnt + 1'b1;
            end
            S_L2_BIAS: r_acc2 <= r_acc2 + w_w2;
            S_OUT: begin
               if (!r_m_valid) begin
                  r_m_valid <= 1'b1;
                  r_m_data  <= w_sat;
               end else if (m_ready) begin
                  r_m_valid <= 1'b0;
                  r_m_data  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Sample buffer and hidden-layer storage (no reset needed, always rewritten before use)
   always_ff @(posedge clk) begin
      if (r_state == S_LOAD && w_s_hs) r_x[r_cnt] <= s_data;
      if (r_state == S_L1_ACT) r_h[r_neuron[HID_W-1:0]] <= tanh_data;
   end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Self-checking bench for mlp_sequencer: LUT stub, golden model, scoreboard queue.
module tb_mlp_sequencer;

   localparam int N1   = 98;
   localparam int N2   = 10;
   localparam int HALF = N1 / 2;

   logic        clk = 1'b0;
   logic        rstn, s_valid, s_ready, m_valid, m_ready, busy;
   logic [7:0]  s_data;
   logic [15:0] m_data;
   logic [1:0]  w_sel;
   logic [3:0]  w_neuron;
   logic [5:0]  w_idx;
   logic [3:0]  w_data, tanh_idx;
   logic [15:0] tanh_data;

   always #5 clk = ~clk;

   mlp_sequencer #(
      .N1(N1), .N2(N2), .W_K(4), .W_X(8), .W_OUT(16), .ACT_SHIFT(4), .OUT_SHIFT(8)
   ) dut (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
      .w_sel(w_sel), .w_neuron(w_neuron), .w_idx(w_idx), .w_data(w_data),
      .tanh_idx(tanh_idx), .tanh_data(tanh_data)
   );

   logic [3:0]  mag [16][64];
   logic [3:0]  pol [16][64];
   logic [3:0]  l2 [64];
   logic [15:0] tt [16];
   logic [7:0]  xv [N1];
   logic [15:0] sb [$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          tanh_hist [16] = '{default: 0};
   int          snap [16];

   // Combinational LUT stub
   always_comb begin
      case (w_sel)
         2'd0:    w_data = mag[w_neuron][w_idx];
         2'd1:    w_data = pol[w_neuron][w_idx];
         2'd2:    w_data = l2[w_idx];
         default: w_data = '0;
      endcase
      tanh_data = tt[tanh_idx];
   end

   // Histogram of tanh_idx per cycle, sampled on the inactive edge
   always @(negedge clk) tanh_hist[tanh_idx] = tanh_hist[tanh_idx] + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sw(input logic [3:0] w);
      return int'($signed(w));
   endfunction

   function automatic logic [15:0] golden();
      int acc1, acc2, t, o, hv;
      acc2 = 0;
      for (int n = 0; n < N2; n++) begin
         acc1 = 0;
         for (int i = 0; i < N1; i++)
            acc1 += sw(i < HALF ? mag[n][i] : pol[n][i-HALF]) * int'($signed(xv[i]));
         acc1 += sw(mag[n][HALF]) + sw(pol[n][HALF]);
         t = acc1 >>> 4;
         if (t > 7) t = 7;
         if (t < -8) t = -8;
         hv = int'($signed(tt[t+8]));
         acc2 += sw(l2[n]) * hv;
      end
      acc2 += sw(l2[N2]);
      o = acc2 >>> 8;
      if (o > 32767) o = 32767;
      if (o < -32768) o = -32768;
      return o[15:0];
   endfunction

   task automatic fill_const(input logic [3:0] w);
      for (int n = 0; n < 16; n++)
         for (int i = 0; i < 64; i++) begin
            mag[n][i] = w;
            pol[n][i] = w;
         end
      for (int i = 0; i < 64; i++) l2[i] = w;
   endtask

   task automatic fill_rand();
      for (int n = 0; n < 16; n++)
         for (int i = 0; i < 64; i++) begin
            mag[n][i] = 4'($urandom_range(0, 15));
            pol[n][i] = 4'($urandom_range(0, 15));
         end
      for (int i = 0; i < 64; i++) l2[i] = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) tt[k] = 16'($urandom);
   endtask

   task automatic rand_x();
      for (int i = 0; i < N1; i++) xv[i] = 8'($urandom);
   endtask

   task automatic take_snap();
      for (int k = 0; k < 16; k++) snap[k] = tanh_hist[k];
   endtask

   task automatic send_vec(input bit gaps);
      int i;
      int guard;
      i = 0;
      guard = 0;
      sb.push_back(golden());
      while (i < N1 && guard < 5000) begin
         s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data  = xv[i];
         if (s_valid && s_ready) i++;
         @(posedge clk); #1;
         guard++;
      end
      s_valid = 1'b0;
      if (i < N1) check("load_timeout", i, N1);
   endtask

   task automatic wait_result(input string tag, output int cycles, output logic [15:0] exp,
                              output logic [15:0] obs);
      cycles = 0;
      exp = '0;
      obs = '0;
      while (!m_valid && cycles < 3000) begin
         @(posedge clk); #1;
         cycles++;
      end
      if (sb.size() > 0) exp = sb.pop_front();
      if (!m_valid) begin
         check({tag, "_timeout"}, 0, 1);
      end else begin
         obs = m_data;
         check(tag, m_data, exp);
         if (m_ready) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      int          cyc;
      logic [15:0] ex, ob, ob_a;
      int          nz;

      rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      fill_const(4'd1);
      for (int k = 0; k < 16; k++) tt[k] = 16'(k * 10);
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_busy", busy, 0);
      rstn = 1'b1;
      #1;
      check("rel_s_ready", s_ready, 1);
      @(posedge clk); #1;

      // 1: all-ones weights and samples, tanh[k]=k*10
      for (int i = 0; i < N1; i++) xv[i] = 8'd1;
      take_snap();
      send_vec(1'b0);
      check("t1_busy", busy, 1);
      check("t1_s_ready_busy", s_ready, 0);
      wait_result("t1_data", cyc, ex, ob);
      check("t1_const", ob, 16'd5);
      check("t1_latency", cyc, 1022);
      check("t1_idx14_count", tanh_hist[14] - snap[14], N2);
      check("t1_load_after", s_ready, 1);

      // 2: activation clamp high and low, large positive/negative layer-2 sums
      fill_const(4'd7);
      for (int i = 0; i < N1; i++) xv[i] = 8'd127;
      take_snap();
      send_vec(1'b0);
      wait_result("t2_pos_data", cyc, ex, ob);
      check("t2_idx15_count", tanh_hist[15] - snap[15], N2);

      fill_const(4'd8);
      take_snap();
      send_vec(1'b0);
      wait_result("t2_neg_data", cyc, ex, ob);
      check("t2_neg_const", ob, 16'hFFFF);
      nz = 0;
      for (int k = 1; k < 16; k++) nz += tanh_hist[k] - snap[k];
      check("t2_idx0_only", nz, 0);

      fill_const(4'd7);
      tt[15] = 16'h7FFF;
      send_vec(1'b0);
      wait_result("t2_big_pos", cyc, ex, ob);
      tt[15] = 16'h8000;
      send_vec(1'b0);
      wait_result("t2_big_neg", cyc, ex, ob);

      // 3: output backpressure
      fill_const(4'd1);
      for (int k = 0; k < 16; k++) tt[k] = 16'(k * 10);
      rand_x();
      m_ready = 1'b0;
      send_vec(1'b0);
      wait_result("t3_data", cyc, ex, ob);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         check("t3_hold_valid", m_valid, 1);
         check("t3_hold_data", m_data, ex);
         check("t3_hold_s_ready", s_ready, 0);
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_s_ready_after", s_ready, 1);
      check("t3_valid_drop", m_valid, 0);

      // 4: reset pulse during layer 1, neuron 4
      fill_rand();
      rand_x();
      send_vec(1'b0);
      repeat (4 * (N1 + 3) + 30) @(posedge clk);
      #1;
      check("t4_busy_pre", busy, 1);
      rstn = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("t4_rst_m_valid", m_valid, 0);
         check("t4_rst_s_ready", s_ready, 0);
      end
      rstn = 1'b1;
      #1;
      check("t4_rel_s_ready", s_ready, 1);
      ex = sb.pop_front();
      @(posedge clk); #1;
      rand_x();
      send_vec(1'b0);
      wait_result("t4_data", cyc, ex, ob);

      // 5: gapped input vs gap-free, back-to-back
      fill_rand();
      rand_x();
      send_vec(1'b0);
      wait_result("t5_nogap", cyc, ex, ob_a);
      send_vec(1'b1);
      wait_result("t5_gap", cyc, ex, ob);
      check("t5_gap_equal", ob, ob_a);
      for (int v = 0; v < 2; v++) begin
         rand_x();
         send_vec(1'b1);
         wait_result("t5_gap_rand", cyc, ex, ob);
      end

      // 6: random tables and vectors, back-to-back
      for (int v = 0; v < 40; v++) begin
         if (v % 10 == 0) fill_rand();
         rand_x();
         send_vec(1'b0);
         wait_result("t6_rand", cyc, ex, ob);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
